if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The clock SHALL be clk: input, 1 bit, rising-edge clock for all state.
REQ-002 The reset SHALL be reset: input, 1 bit, synchronous, active-high.
REQ-003 inst_sram_en SHALL be an output, 1 bit: the instruction SRAM read enable.
REQ-004 inst_sram_we SHALL be an output, 1 bit, tied to 0.
REQ-005 inst_sram_addr SHALL be an output, 32 bits: the read address, equal to nextpc.
REQ-006 inst_sram_wdata SHALL be an output, 32 bits, tied to 0.
REQ-007 inst_sram_rdata SHALL be an input, 32 bits: read data, valid the cycle after an enabled read.
REQ-008 br_bus SHALL be an input, 33 bits: {br_taken[32], br_target[31:0]}, driven by decode.
REQ-009 ds_allowin SHALL be an input, 1 bit: decode can accept an instruction this cycle.
REQ-010 fs_to_ds_valid SHALL be an output, 1 bit: fs_to_ds_bus holds a live instruction.
REQ-011 fs_to_ds_bus SHALL be an output, 64 bits: {fs_inst[63:32], fs_pc[31:0]}.

Function
REQ-012 State SHALL be: fs_valid, fs_pc[31:0], inst_buf[31:0], buf_valid.
REQ-013 to_fs_valid SHALL be ~reset.
REQ-014 seq_pc SHALL be fs_pc + 4, with 32-bit wrap-around and no carry out.
REQ-015 nextpc SHALL be br_target when br_taken=1, else seq_pc.
REQ-016 fs_ready_go SHALL be 1.
REQ-017 fs_allowin SHALL be !fs_valid || (fs_ready_go && ds_allowin) || br_taken.
- Rationale: a branch discards the wrong-path IF instruction, which frees the stage.
REQ-018 inst_sram_en SHALL be to_fs_valid && fs_allowin.
- When this is 0, no read occurs and the SRAM output holds.
REQ-019 When fs_allowin=1, fs_valid SHALL load to_fs_valid on the next edge.
- When to_fs_valid=1 in that case, fs_pc SHALL also load nextpc.
REQ-020 When fs_allowin=0, fs_valid and fs_pc SHALL hold.
REQ-021 fs_to_ds_valid SHALL be fs_valid && fs_ready_go && !br_taken.
- A branch cancels the IF instruction combinationally in the same cycle.
REQ-022 fs_inst SHALL be inst_buf when buf_valid=1, else inst_sram_rdata.
REQ-023 inst_buf capture: when fs_valid=1, buf_valid=0, ds_allowin=0 and br_taken=0, the stage SHALL set inst_buf to inst_sram_rdata and buf_valid to 1.
REQ-024 buf_valid SHALL clear on any edge where fs_allowin=1.
- Covers both a handoff to decode and a branch cancel.
REQ-025 While buf_valid=1 and the stage is stalled, inst_buf SHALL NOT be overwritten.
REQ-026 Latency SHALL be 1 cycle: address issued at edge N gives fs_to_ds_valid with that pc after edge N+1, absent cancel.
REQ-027 Simultaneous br_taken=1 and ds_allowin=0 SHALL:
- redirect: inst_sram_addr = br_target, en=1;
- drop the current instruction;
- clear buf_valid.
REQ-028 br_taken SHALL be honoured only while to_fs_valid=1.
- During reset, nextpc is still computed, but no state other than the reset values SHALL be loaded.
REQ-029 No instruction SHALL be delivered twice, and none skipped, across any stall length from 0 to unbounded.

Reset
REQ-030 While reset=1, the stage SHALL hold these values:
- fs_valid=0, buf_valid=0;
- fs_pc=0x1bfffffc, inst_buf=0;
- fs_to_ds_valid=0, inst_sram_en=0.
REQ-031 Reset SHALL take priority over all other inputs, including mid-stall and a simultaneous br_taken.
REQ-032 In the first cycle after reset, nextpc SHALL be 0x1c000000 with inst_sram_en=1.

Verification
REQ-033 Reset release: reset 1->0, ds_allowin=1 -> cycle 0: addr=0x1c000000, en=1; cycle 1: fs_to_ds_valid=1, bus pc=0x1c000000, inst = SRAM word.
REQ-034 Streaming: ds_allowin=1 for 4 cycles -> addresses 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c; each pc is delivered exactly once.
REQ-035 Stall with buffer: fs_pc=0x1c000008, inst=0x02804021, ds_allowin=0 for 3 cycles, rdata forced to 0xdeadbeef after the first stall cycle -> bus holds {0x02804021, 0x1c000008}, en=0; on release the next pc is 0x1c00000c.
REQ-036 Branch: fs_pc=0x1c000008, br_bus={1, 0x1c000100}, ds_allowin=1 -> same cycle: fs_to_ds_valid=0, addr=0x1c000100; next cycle: pc=0x1c000100.
REQ-037 Branch during stall: buf_valid=1, ds_allowin=0, br_taken=1 with target 0x1c000200 -> en=1, addr=0x1c000200; next cycle: buf_valid=0, pc=0x1c000200 delivered from fresh rdata.
REQ-038 Reset mid-stall: buf_valid=1, fs_pc=0x1c000040, assert reset -> next edge: all REQ-030 values; after release, fetch restarts at 0x1c000000.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage feeding decode, with a one-entry buffer that
// holds the fetched word while decode stalls and the SRAM output goes stale.
module if_stage (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_sram_en,
   output logic        inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   input  logic [32:0] br_bus,
   input  logic        ds_allowin,
   output logic        fs_to_ds_valid,
   output logic [63:0] fs_to_ds_bus
);
   logic        fs_valid, buf_valid, to_fs_valid, fs_ready_go, fs_allowin, br_taken;
   logic [31:0] fs_pc, inst_buf, seq_pc, nextpc, fs_inst;

   assign to_fs_valid     = ~reset;
   assign fs_ready_go     = 1'b1;
   // a redirect only counts once the stage is out of reset
   assign br_taken        = br_bus[32] & to_fs_valid;
   assign seq_pc          = fs_pc + 32'd4;
   assign nextpc          = br_bus[32] ? br_bus[31:0] : seq_pc;
   assign fs_allowin      = !fs_valid || (fs_ready_go && ds_allowin) || br_taken;
   assign inst_sram_en    = to_fs_valid && fs_allowin;
   assign inst_sram_we    = 1'b0;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_wdata = 32'd0;
   assign fs_to_ds_valid  = fs_valid && fs_ready_go && !br_taken;
   assign fs_inst         = buf_valid ? inst_buf : inst_sram_rdata;
   assign fs_to_ds_bus    = {fs_inst, fs_pc};

   always_ff @(posedge clk) begin
      if (reset) begin
         fs_valid  <= 1'b0;
         fs_pc     <= 32'h1bff_fffc;
         buf_valid <= 1'b0;
         inst_buf  <= 32'd0;
      end else if (fs_allowin) begin
         fs_valid  <= to_fs_valid;
         fs_pc     <= nextpc;
         buf_valid <= 1'b0;
      end else if (!buf_valid) begin
         // stalled with a live word: keep it before the SRAM output is reused
         inst_buf  <= inst_sram_rdata;
         buf_valid <= 1'b1;
      end
   end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage; expected {inst, pc} pairs are queued
// by the stimulus and popped on every fs_to_ds handshake.
module tb_if_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inst_sram_en, inst_sram_we;
   logic [31:0] inst_sram_addr, inst_sram_wdata;
   logic [31:0] inst_sram_rdata = 32'd0;
   logic [32:0] br_bus = 33'd0;
   logic        ds_allowin = 1'b1;
   logic        fs_to_ds_valid;
   logic [63:0] fs_to_ds_bus;
   logic        force_junk = 1'b0;
   int          tests = 0, fails = 0;
   logic [63:0] sb_q[$];

   if_stage dut (
      .clk(clk), .reset(reset),
      .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_rdata(inst_sram_rdata), .br_bus(br_bus), .ds_allowin(ds_allowin),
      .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a == 32'h1c00_0008) ? 32'h0280_4021 : {a[15:0], ~a[15:0]};
   endfunction

   // synchronous SRAM; force_junk corrupts the output to expose a stale-read bug
   always @(posedge clk) begin
      if (force_junk) inst_sram_rdata <= 32'hdead_beef;
      else if (inst_sram_en) inst_sram_rdata <= word(inst_sram_addr);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && fs_to_ds_valid && ds_allowin) begin
         logic [63:0] exp;
         exp = 64'hx;
         if (sb_q.size() > 0) exp = sb_q.pop_front();
         check("deliver", fs_to_ds_bus, exp);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc);
      sb_q.push_back({word(pc), pc});
   endtask

   // reset, release and stream until fs_pc = 0x1c000008 (returns just after that edge)
   task automatic restart();
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      reset = 1'b1; br_bus = 33'd0; ds_allowin = 1'b1; force_junk = 1'b0;
      step(); step();
      @(negedge clk);
      check("rst_valid", 64'(fs_to_ds_valid), 64'd0);
      check("rst_en", 64'(inst_sram_en), 64'd0);
      check("rst_we_wdata", {31'd0, inst_sram_we, inst_sram_wdata}, 64'd0);
      step();
      reset = 1'b0;
      push(32'h1c00_0000);
      @(negedge clk);
      check("c0_addr", 64'(inst_sram_addr), 64'h1c00_0000);
      check("c0_en", 64'(inst_sram_en), 64'd1);
      check("c0_valid", 64'(fs_to_ds_valid), 64'd0);
      step();
      push(32'h1c00_0004);
      @(negedge clk);
      check("c1_addr", 64'(inst_sram_addr), 64'h1c00_0004);
      step();
      @(negedge clk);
      check("c2_addr", 64'(inst_sram_addr), 64'h1c00_0008);
      step();
   endtask

   initial begin
      // streaming, then a 3-cycle stall with the SRAM output corrupted
      restart();
      ds_allowin = 1'b0;
      force_junk = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_bus", fs_to_ds_bus, {32'h0280_4021, 32'h1c00_0008});
         check("stall_valid", 64'(fs_to_ds_valid), 64'd1);
         check("stall_en", 64'(inst_sram_en), 64'd0);
         step();
      end
      ds_allowin = 1'b1;
      force_junk = 1'b0;
      push(32'h1c00_0008);
      @(negedge clk);
      check("release_addr", 64'(inst_sram_addr), 64'h1c00_000c);
      check("release_en", 64'(inst_sram_en), 64'd1);
      step();
      push(32'h1c00_000c);
      @(negedge clk);
      step();
      // branch while streaming
      restart();
      br_bus = {1'b1, 32'h1c00_0100};
      @(negedge clk);
      check("br_valid", 64'(fs_to_ds_valid), 64'd0);
      check("br_addr", 64'(inst_sram_addr), 64'h1c00_0100);
      check("br_en", 64'(inst_sram_en), 64'd1);
      push(32'h1c00_0100);
      step();
      br_bus = 33'd0;
      @(negedge clk);
      step();
      // branch while the buffer holds a stalled word
      restart();
      ds_allowin = 1'b0;
      @(negedge clk);
      check("bst_valid", 64'(fs_to_ds_valid), 64'd1);
      step();
      br_bus = {1'b1, 32'h1c00_0200};
      @(negedge clk);
      check("bst_en", 64'(inst_sram_en), 64'd1);
      check("bst_addr", 64'(inst_sram_addr), 64'h1c00_0200);
      check("bst_valid0", 64'(fs_to_ds_valid), 64'd0);
      push(32'h1c00_0200);
      step();
      br_bus = 33'd0;
      ds_allowin = 1'b1;
      @(negedge clk);
      step();
      // reset mid-stall with a simultaneous branch
      restart();
      ds_allowin = 1'b0;
      step();
      reset = 1'b1;
      br_bus = {1'b1, 32'h1c00_0300};
      @(negedge clk);
      check("rms_en", 64'(inst_sram_en), 64'd0);
      step();
      @(negedge clk);
      check("rms_valid", 64'(fs_to_ds_valid), 64'd0);
      check("rms_en2", 64'(inst_sram_en), 64'd0);
      step();
      reset = 1'b0;
      br_bus = 33'd0;
      ds_allowin = 1'b1;
      push(32'h1c00_0000);
      @(negedge clk);
      check("rms_addr", 64'(inst_sram_addr), 64'h1c00_0000);
      check("rms_en3", 64'(inst_sram_en), 64'd1);
      step();
      @(negedge clk);
      step();
      ds_allowin = 1'b0;
      reset = 1'b1;
      check("sb_final", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
